// File: rtl/br_amba_apb2axil.sv
// APB completer to AXI4-Lite manager bridge.
//
// Accepts one APB transfer at a time, captures the setup-phase request into
// registers, replays it as a single AXI4-Lite read or write, and completes
// the APB access phase with pready once the AXI response has been received.
// AXI address, data, strobe and prot are driven only from the captured
// registers, so they cannot move while a valid is pending.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   psel_i, penable_i, paddr_i,
//   pwrite_i, pwdata_i, pstrb_i,
//   pprot_i                         APB request
//   prdata_o, pready_o, pslverr_o   APB completion
//   aw*_o / awready_i               AXI write address channel
//   w*_o  / wready_i                AXI write data channel
//   bresp_i, bvalid_i / bready_o    AXI write response channel
//   ar*_o / arready_i               AXI read address channel
//   rdata_i, rresp_i, rvalid_i /
//   rready_o                        AXI read data channel
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for an APB setup phase
// WR_REQ  | awvalid/wvalid presented, each dropped after its own handshake
// WR_RESP | bready high, waiting for bvalid
// RD_REQ  | arvalid presented, waiting for arready
// RD_RESP | rready high, waiting for rvalid
// DONE    | pready pulse to the APB requester, back to IDLE next cycle

module br_amba_apb2axil #(
  parameter int AddrWidth = 12,
  parameter int DataWidth = 32,
  localparam int StrbWidth = DataWidth / 8,
  localparam int ApbProtWidth = 3,
  localparam int AxiProtWidth = 3,
  localparam int AxiRespWidth = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  // APB completer
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic [AddrWidth-1:0]    paddr_i,
  input  logic                    pwrite_i,
  input  logic [DataWidth-1:0]    pwdata_i,
  input  logic [StrbWidth-1:0]    pstrb_i,
  input  logic [ApbProtWidth-1:0] pprot_i,
  output logic [DataWidth-1:0]    prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  // AXI4-Lite AW
  output logic [AddrWidth-1:0]    awaddr_o,
  output logic [AxiProtWidth-1:0] awprot_o,
  output logic                    awvalid_o,
  input  logic                    awready_i,
  // AXI4-Lite W
  output logic [DataWidth-1:0]    wdata_o,
  output logic [StrbWidth-1:0]    wstrb_o,
  output logic                    wvalid_o,
  input  logic                    wready_i,
  // AXI4-Lite B
  input  logic [AxiRespWidth-1:0] bresp_i,
  input  logic                    bvalid_i,
  output logic                    bready_o,
  // AXI4-Lite AR
  output logic [AddrWidth-1:0]    araddr_o,
  output logic [AxiProtWidth-1:0] arprot_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  // AXI4-Lite R
  input  logic [DataWidth-1:0]    rdata_i,
  input  logic [AxiRespWidth-1:0] rresp_i,
  input  logic                    rvalid_i,
  output logic                    rready_o
);

  if (AddrWidth < 12) begin : gen_bad_addr_width
    $error("br_amba_apb2axil: AddrWidth must be at least 12");
  end
  if (DataWidth < 32 || (DataWidth & (DataWidth - 1)) != 0) begin : gen_bad_data_width
    $error("br_amba_apb2axil: DataWidth must be a power of two and at least 32");
  end

  localparam logic [5:0] S_IDLE    = 6'b000001;
  localparam logic [5:0] S_WR_REQ  = 6'b000010;
  localparam logic [5:0] S_WR_RESP = 6'b000100;
  localparam logic [5:0] S_RD_REQ  = 6'b001000;
  localparam logic [5:0] S_RD_RESP = 6'b010000;
  localparam logic [5:0] S_DONE    = 6'b100000;

  logic [5:0]              state_q, state_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [StrbWidth-1:0]    strb_q, strb_d;
  logic [AxiProtWidth-1:0] prot_q, prot_d;
  logic                    aw_pend_q, aw_pend_d;
  logic                    w_pend_q, w_pend_d;
  logic [DataWidth-1:0]    prdata_q, prdata_d;
  logic                    err_q, err_d;

  // Only resp[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  logic unused_resp_lsb;
  assign unused_resp_lsb = bresp_i[0] ^ rresp_i[0];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    prdata_d  = prdata_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        // An access phase without a prior setup is deliberately ignored.
        if (psel_i && !penable_i) begin
          addr_d  = paddr_i;
          wdata_d = pwdata_i;
          strb_d  = pstrb_i;
          prot_d  = pprot_i;
          if (pwrite_i) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = S_WR_REQ;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        aw_pend_d = aw_pend_q && !awready_i;
        w_pend_d  = w_pend_q && !wready_i;
        if (!aw_pend_d && !w_pend_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (bvalid_i) begin
          err_d   = bresp_i[1];
          state_d = S_DONE;
        end
      end
      S_RD_REQ: begin
        if (arready_i) state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (rvalid_i) begin
          prdata_d = rdata_i;
          err_d    = rresp_i[1];
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      prdata_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      prdata_q  <= prdata_d;
      err_q     <= err_d;
    end
  end

  // Handshake outputs decode straight from the registered state so that an
  // asynchronous reset clears them in the same instant.
  assign awvalid_o = (state_q == S_WR_REQ) && aw_pend_q;
  assign wvalid_o  = (state_q == S_WR_REQ) && w_pend_q;
  assign bready_o  = (state_q == S_WR_RESP);
  assign arvalid_o = (state_q == S_RD_REQ);
  assign rready_o  = (state_q == S_RD_RESP);
  assign pready_o  = (state_q == S_DONE);
  assign pslverr_o = (state_q == S_DONE) && err_q;
  assign prdata_o  = prdata_q;

  assign awaddr_o = addr_q;
  assign araddr_o = addr_q;
  assign awprot_o = prot_q;
  assign arprot_o = prot_q;
  assign wdata_o  = wdata_q;
  assign wstrb_o  = strb_q;

  a_state_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot(state_q));
  a_access_without_setup: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_IDLE) |-> !(psel_i && penable_i));
  a_psel_dropped_early: assert property (@(posedge clk) disable iff (rst)
    (state_q != S_IDLE) |-> psel_i);
  a_aw_stable: assert property (@(posedge clk) disable iff (rst)
    (awvalid_o && !awready_i) |=> ($stable(awaddr_o) && $stable(awprot_o)));
  a_w_stable: assert property (@(posedge clk) disable iff (rst)
    (wvalid_o && !wready_i) |=> ($stable(wdata_o) && $stable(wstrb_o)));
  a_ar_stable: assert property (@(posedge clk) disable iff (rst)
    (arvalid_o && !arready_i) |=> ($stable(araddr_o) && $stable(arprot_o)));

endmodule

// File: tb/tb_br_amba_apb2axil.sv
module tb_br_amba_apb2axil;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic [2:0]    pprot;
  logic [DW-1:0] prdata_o;
  logic          pready_o, pslverr_o;
  logic [AW-1:0] awaddr_o, araddr_o;
  logic [2:0]    awprot_o, arprot_o;
  logic          awvalid_o, awready_i;
  logic [DW-1:0] wdata_o;
  logic [SW-1:0] wstrb_o;
  logic          wvalid_o, wready_i;
  logic [1:0]    bresp_i, rresp_i;
  logic          bvalid_i, bready_o;
  logic          arvalid_o, arready_i;
  logic [DW-1:0] rdata_i;
  logic          rvalid_i, rready_o;

  always #5 clk = ~clk;

  br_amba_apb2axil #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk(clk), .rst(rst),
    .psel_i(psel), .penable_i(penable), .paddr_i(paddr), .pwrite_i(pwrite),
    .pwdata_i(pwdata), .pstrb_i(pstrb), .pprot_i(pprot),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Expected traffic: {prdata, pslverr}, {prot, addr}, {data, strb}.
  logic [32:0] rsp_q[$];
  logic [14:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [14:0] ar_q[$];

  // AXI slave behaviour knobs, written by the stimulus
  int         cfg_aw_dly = 0;
  int         cfg_w_dly = 0;
  int         cfg_r_dly = 0;
  logic [1:0] cfg_bresp = 2'b00;
  logic [1:0] cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  logic       b_poke = 1'b0;

  // AXI slave model plus address/data monitor
  initial begin
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_got, w_got, b_pend, r_pend;
    int aw_wait, w_wait, r_cnt;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
    aw_wait = 0; w_wait = 0; r_cnt = 0;
    awready_i = 0; wready_i = 0; arready_i = 0;
    bvalid_i = 0; bresp_i = 0; rvalid_i = 0; rresp_i = 0; rdata_i = 0;
    forever begin
      @(negedge clk);
      aw_hs = awvalid_o && awready_i;
      w_hs  = wvalid_o && wready_i;
      b_hs  = bvalid_i && bready_o;
      ar_hs = arvalid_o && arready_i;
      r_hs  = rvalid_i && rready_o;
      if (aw_hs) begin
        check("aw_expected", aw_q.size() != 0, 1);
        if (aw_q.size() != 0) check("aw_prot_addr", {awprot_o, awaddr_o}, aw_q.pop_front());
        aw_got = 1; aw_wait = 0;
      end else if (awvalid_o) aw_wait++;
      if (w_hs) begin
        check("w_expected", w_q.size() != 0, 1);
        if (w_q.size() != 0) check("w_data_strb", {wdata_o, wstrb_o}, w_q.pop_front());
        w_got = 1; w_wait = 0;
      end else if (wvalid_o) w_wait++;
      if (ar_hs) begin
        check("ar_expected", ar_q.size() != 0, 1);
        if (ar_q.size() != 0) check("ar_prot_addr", {arprot_o, araddr_o}, ar_q.pop_front());
        r_pend = 1; r_cnt = cfg_r_dly;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_wait = 0; w_wait = 0;
        awready_i = 0; wready_i = 0; arready_i = 0;
        bvalid_i = 0; rvalid_i = 0;
      end else begin
        awready_i = (aw_wait >= cfg_aw_dly);
        wready_i  = (w_wait >= cfg_w_dly);
        arready_i = 1;
        if (b_hs) b_pend = 0;
        if (aw_got && w_got) begin
          b_pend = 1; bresp_i = cfg_bresp; aw_got = 0; w_got = 0;
        end
        bvalid_i = b_pend | b_poke;
        b_poke = 0;
        if (r_hs) rvalid_i = 0;
        if (r_pend) begin
          if (r_cnt == 0) begin
            rvalid_i = 1; rdata_i = cfg_rdata; rresp_i = cfg_rresp; r_pend = 0;
          end else r_cnt--;
        end
      end
    end
  end

  // APB response monitor
  initial begin
    logic prev_ready;
    logic [32:0] exp;
    prev_ready = 0;
    forever begin
      @(negedge clk);
      if (prev_ready) check("pready_one_cycle", pready_o, 0);
      if (!rst && pready_o) begin
        check("pready_expected", rsp_q.size() != 0, 1);
        if (rsp_q.size() != 0) begin
          exp = rsp_q.pop_front();
          check("prdata", prdata_o, exp[32:1]);
          check("pslverr", pslverr_o, exp[0]);
        end
      end else if (!rst) begin
        check("pslverr_outside_done", pslverr_o, 0);
      end
      prev_ready = pready_o;
    end
  end

  task automatic apb_start(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
  endtask

  task automatic wait_pready(inout int lat);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (pready_o) return;
    end
    check("pready_timeout", pready_o, 1);
  endtask

  // Setup cycle counts as cycle 1; returns the cycle in which pready was seen.
  task automatic apb_finish(output int lat);
    lat = 0;
    @(negedge clk); lat = 1;
    @(posedge clk); #1 penable = 1;
    wait_pready(lat);
  endtask

  task automatic apb_idle();
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awvalid"}, awvalid_o, 0);
    check({tag, "_wvalid"}, wvalid_o, 0);
    check({tag, "_arvalid"}, arvalid_o, 0);
    check({tag, "_bready"}, bready_o, 0);
    check({tag, "_rready"}, rready_o, 0);
    check({tag, "_pready"}, pready_o, 0);
    check({tag, "_pslverr"}, pslverr_o, 0);
    check({tag, "_prdata"}, prdata_o, 0);
  endtask

  logic [31:0] last_rd;
  int lat;

  initial begin
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; pprot = 0;
    last_rd = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst = 0;

    // Basic write, zero-wait AXI
    aw_q.push_back({3'b010, 12'h100});
    w_q.push_back({32'hDEADBEEF, 4'hF});
    rsp_q.push_back({last_rd, 1'b0});
    apb_start(1, 12'h100, 32'hDEADBEEF, 4'hF, 3'b010);
    apb_finish(lat);
    check("write_latency", lat, 4);
    apb_idle();

    // Read with rvalid delayed, SLVERR
    cfg_r_dly = 3; cfg_rdata = 32'h12345678; cfg_rresp = 2'b10;
    ar_q.push_back({3'b001, 12'h204});
    last_rd = 32'h12345678;
    rsp_q.push_back({last_rd, 1'b1});
    apb_start(0, 12'h204, 32'h0, 4'h0, 3'b001);
    apb_finish(lat);
    apb_idle();
    cfg_r_dly = 0;

    // Skewed write: W accepted two cycles before AW, EXOKAY response
    cfg_aw_dly = 2; cfg_bresp = 2'b01;
    aw_q.push_back({3'b000, 12'h008});
    w_q.push_back({32'h0000_1111, 4'h5});
    rsp_q.push_back({last_rd, 1'b0});
    apb_start(1, 12'h008, 32'h0000_1111, 4'h5, 3'b000);
    @(negedge clk); lat = 1;
    @(posedge clk); #1 penable = 1;
    @(negedge clk); lat++;
    check("skew_c1_awvalid", awvalid_o, 1);
    check("skew_c1_wvalid", wvalid_o, 1);
    check("skew_c1_bready", bready_o, 0);
    @(negedge clk); lat++;
    check("skew_c2_awvalid", awvalid_o, 1);
    check("skew_c2_wvalid", wvalid_o, 0);
    check("skew_c2_bready", bready_o, 0);
    @(negedge clk); lat++;
    check("skew_c3_awvalid", awvalid_o, 1);
    check("skew_c3_bready", bready_o, 0);
    @(negedge clk); lat++;
    check("skew_c4_awvalid", awvalid_o, 0);
    check("skew_c4_bready", bready_o, 1);
    wait_pready(lat);
    check("skew_latency", lat, 6);
    apb_idle();
    cfg_aw_dly = 0;

    // Back-to-back: DECERR write, then read set up in the cycle after Done
    cfg_bresp = 2'b11; cfg_rdata = 32'hCAFEF00D; cfg_rresp = 2'b00;
    aw_q.push_back({3'b100, 12'h030});
    w_q.push_back({32'hA5A55A5A, 4'hC});
    rsp_q.push_back({last_rd, 1'b1});
    apb_start(1, 12'h030, 32'hA5A55A5A, 4'hC, 3'b100);
    apb_finish(lat);
    check("b2b_write_latency", lat, 4);
    ar_q.push_back({3'b011, 12'h034});
    last_rd = 32'hCAFEF00D;
    rsp_q.push_back({last_rd, 1'b0});
    apb_start(0, 12'h034, 32'h0, 4'h0, 3'b011);
    apb_finish(lat);
    check("b2b_read_latency", lat, 4);
    apb_idle();
    cfg_bresp = 2'b00;

    // Reset asserted while waiting in RdResp
    cfg_r_dly = 20; cfg_rdata = 32'h77777777;
    ar_q.push_back({3'b000, 12'h040});
    apb_start(0, 12'h040, 32'h0, 4'h0, 3'b000);
    @(negedge clk);
    @(posedge clk); #1 penable = 1;
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (rready_o) seen = 1;
      end
      check("reach_rdresp", rready_o, 1);
    end
    #2 rst = 1;
    #1 check_all_zero("midrst");
    @(posedge clk); #1 psel = 0; penable = 0;
    @(posedge clk); #1 rst = 0;
    cfg_r_dly = 0;
    last_rd = 32'h0;

    aw_q.push_back({3'b001, 12'h7FC});
    w_q.push_back({32'h0BADF00D, 4'h3});
    rsp_q.push_back({last_rd, 1'b0});
    apb_start(1, 12'h7FC, 32'h0BADF00D, 4'h3, 3'b001);
    apb_finish(lat);
    check("post_reset_latency", lat, 4);
    apb_idle();

    // Stray bvalid while idle must be ignored
    @(negedge clk) b_poke = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_bready", bready_o, 0);
      check("idle_pready", pready_o, 0);
    end

    cfg_rdata = 32'h000055AA; cfg_rresp = 2'b00;
    ar_q.push_back({3'b000, 12'h010});
    last_rd = 32'h000055AA;
    rsp_q.push_back({last_rd, 1'b0});
    apb_start(0, 12'h010, 32'h0, 4'h0, 3'b000);
    apb_finish(lat);
    check("final_read_latency", lat, 4);
    apb_idle();

    repeat (3) @(negedge clk);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("aw_queue_drained", aw_q.size(), 0);
    check("w_queue_drained", w_q.size(), 0);
    check("ar_queue_drained", ar_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
